// File: rtl/backprop_pkg.sv
// backprop_pkg: FSM states, default fixed-point format and the saturating clamp shared by the backprop datapath.
package backprop_pkg;

   typedef enum logic [1:0] {IDLE, FWD, UPD, DONE} state_e;

   localparam int FRAC_BITS_DEFAULT = 16;
   localparam int SAT_W = 128;

   // Clamp a wide signed value into the range of a w-bit two's-complement word.
   function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W-1:0] v, input int w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (128'sd1 <<< (w - 1)) - 128'sd1;
      lo = -hi - 128'sd1;
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

endpackage

// File: rtl/backprop_unit_fxp_mul.sv
// fxp_mul: combinational signed fixed-point multiply (full product, arithmetic shift, wrap or clamp under BP_SATURATE_EN).
module fxp_mul
   import backprop_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
   input  logic signed [WIDTH-1:0] a_i,
   input  logic signed [WIDTH-1:0] b_i,
   output logic signed [WIDTH-1:0] p_o
);

   localparam int AW = 2 * WIDTH;

   logic signed [AW-1:0] full;

   assign full = AW'(a_i) * AW'(b_i);

`ifdef BP_SATURATE_EN
   assign p_o = WIDTH'(sat_clamp(SAT_W'(full >>> FRAC_BITS), WIDTH));
`else
   assign p_o = WIDTH'(full >>> FRAC_BITS);
`endif

endmodule

// File: rtl/backprop_unit.sv
// backprop_unit: lane-serial neuron training step (forward re-sum + ReLU gate, then error terms and weight update).
// Optional BP_SATURATE_EN clamps every product and the weight update instead of wrapping.
module backprop_unit
   import backprop_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = FRAC_BITS_DEFAULT,
   parameter int N_INPUTS  = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [N_INPUTS*WIDTH-1:0]   prev,
   input  logic [N_INPUTS*WIDTH-1:0]   weight,
   input  logic [WIDTH-1:0]            delta_in,
   input  logic [WIDTH-1:0]            rate,
   output logic                        busy,
   output logic                        done,
   output logic                        gate,
   output logic [N_INPUTS*WIDTH-1:0]   delta_out,
   output logic [N_INPUTS*WIDTH-1:0]   weight_new
);

   localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam int AW = 2 * WIDTH;
   localparam logic [IW-1:0] LAST = IW'(N_INPUTS - 1);

   state_e                      state_q;
   logic [IW-1:0]               idx_q;
   logic [IW-1:0]               idx_d;
   logic signed [AW-1:0]        acc_q;
   logic signed [AW-1:0]        acc_d;
   logic                        gate_q;
   logic                        busy_q;
   logic                        done_q;
   logic [N_INPUTS*WIDTH-1:0]   prev_q;
   logic [N_INPUTS*WIDTH-1:0]   weight_q;
   logic [WIDTH-1:0]            delta_q;
   logic [WIDTH-1:0]            rate_q;
   logic [N_INPUTS*WIDTH-1:0]   delta_out_q;
   logic [N_INPUTS*WIDTH-1:0]   weight_new_q;

   logic signed [WIDTH-1:0]     prev_l;
   logic signed [WIDTH-1:0]     weight_l;
   logic signed [WIDTH-1:0]     d_eff;
   logic signed [WIDTH-1:0]     lane_b;
   logic signed [WIDTH-1:0]     lane_p;
   logic signed [WIDTH-1:0]     err_p;
   logic signed [WIDTH-1:0]     step_p;
   logic signed [WIDTH-1:0]     wsum;

   assign prev_l   = prev_q[idx_q*WIDTH +: WIDTH];
   assign weight_l = weight_q[idx_q*WIDTH +: WIDTH];
   assign d_eff    = gate_q ? delta_q : '0;
   // The shared lane multiplier forms prev*weight in FWD and prev*d in UPD.
   assign lane_b   = (state_q == FWD) ? weight_l : d_eff;
   assign acc_d    = acc_q + AW'(lane_p);
   assign idx_d    = (idx_q == LAST) ? '0 : idx_q + 1'b1;

   fxp_mul #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_lane (
      .a_i (prev_l),
      .b_i (lane_b),
      .p_o (lane_p)
   );

   fxp_mul #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_err (
      .a_i (weight_l),
      .b_i (d_eff),
      .p_o (err_p)
   );

   fxp_mul #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_rate (
      .a_i (lane_p),
      .b_i (rate_q),
      .p_o (step_p)
   );

`ifdef BP_SATURATE_EN
   logic signed [WIDTH:0] wide;
   assign wide = (WIDTH+1)'(weight_l) + (WIDTH+1)'(step_p);
   assign wsum = WIDTH'(sat_clamp(SAT_W'(wide), WIDTH));
`else
   assign wsum = weight_l + step_p;
`endif

   // Control FSM: latch operands, sweep lanes for the forward sum, then sweep lanes for errors and updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         acc_q        <= '0;
         gate_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         prev_q       <= '0;
         weight_q     <= '0;
         delta_q      <= '0;
         rate_q       <= '0;
         delta_out_q  <= '0;
         weight_new_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  prev_q   <= prev;
                  weight_q <= weight;
                  delta_q  <= delta_in;
                  rate_q   <= rate;
                  acc_q    <= '0;
                  idx_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= FWD;
               end
            end
            FWD: begin
               acc_q <= acc_d;
               idx_q <= idx_d;
               if (idx_q == LAST) begin
                  gate_q  <= ~acc_d[AW-1];
                  state_q <= UPD;
               end
            end
            UPD: begin
               delta_out_q[idx_q*WIDTH +: WIDTH]  <= err_p;
               weight_new_q[idx_q*WIDTH +: WIDTH] <= wsum;
               idx_q <= idx_d;
               if (idx_q == LAST) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign gate       = gate_q;
   assign delta_out  = delta_out_q;
   assign weight_new = weight_new_q;

endmodule

// File: tb/tb_backprop_unit.sv
// tb_backprop_unit: randomized and directed checks of backprop_unit against an arithmetic reference model.
module tb_backprop_unit;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [127:0] prev = '0;
   logic [127:0] weight = '0;
   logic [31:0]  delta_in = '0;
   logic [31:0]  rate = '0;
   logic         busy;
   logic         done;
   logic         gate;
   logic [127:0] delta_out;
   logic [127:0] weight_new;

   logic         start1 = 1'b0;
   logic [31:0]  prev1 = '0;
   logic [31:0]  weight1 = '0;
   logic [31:0]  delta1 = '0;
   logic [31:0]  rate1 = '0;
   logic         busy1;
   logic         done1;
   logic         gate1;
   logic [31:0]  dout1;
   logic [31:0]  wnew1;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   backprop_unit #(.WIDTH(32), .FRAC_BITS(16), .N_INPUTS(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .prev       (prev),
      .weight     (weight),
      .delta_in   (delta_in),
      .rate       (rate),
      .busy       (busy),
      .done       (done),
      .gate       (gate),
      .delta_out  (delta_out),
      .weight_new (weight_new)
   );

   backprop_unit #(.WIDTH(32), .FRAC_BITS(16), .N_INPUTS(1)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .start      (start1),
      .prev       (prev1),
      .weight     (weight1),
      .delta_in   (delta1),
      .rate       (rate1),
      .busy       (busy1),
      .done       (done1),
      .gate       (gate1),
      .delta_out  (dout1),
      .weight_new (wnew1)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic signed [31:0] fxp(input logic signed [31:0] a, input logic signed [31:0] b);
      longint p;
      p = (longint'(a) * longint'(b)) >>> 16;
`ifdef BP_SATURATE_EN
      if (p > 64'sh7FFFFFFF) p = 64'sh7FFFFFFF;
      if (p < -64'sh80000000) p = -64'sh80000000;
`endif
      return p[31:0];
   endfunction

   function automatic logic signed [31:0] wadd(input logic signed [31:0] a, input logic signed [31:0] b);
      longint s;
      s = longint'(a) + longint'(b);
`ifdef BP_SATURATE_EN
      if (s > 64'sh7FFFFFFF) s = 64'sh7FFFFFFF;
      if (s < -64'sh80000000) s = -64'sh80000000;
`endif
      return s[31:0];
   endfunction

   function automatic void model(input logic [127:0] p, input logic [127:0] w, input logic signed [31:0] d,
                                 input logic signed [31:0] r, output logic g, output logic [127:0] dout,
                                 output logic [127:0] wnew);
      longint acc = 0;
      logic signed [31:0] dd;
      for (int i = 0; i < 4; i++) acc += longint'(fxp(p[i*32 +: 32], w[i*32 +: 32]));
      g = (acc >= 0);
      dd = g ? d : 32'sd0;
      for (int i = 0; i < 4; i++) begin
         dout[i*32 +: 32] = fxp(w[i*32 +: 32], dd);
         wnew[i*32 +: 32] = wadd(w[i*32 +: 32], fxp(fxp(p[i*32 +: 32], dd), r));
      end
   endfunction

   function automatic logic [31:0] rv();
      logic [31:0] x;
      x = $urandom;
      return ($urandom_range(0, 3) == 0) ? x : {{12{x[19]}}, x[19:0]};
   endfunction

   // Full operation on the 4-lane unit; returns to IDLE before exiting.
   task automatic op4(input string tag, input logic [127:0] p, input logic [127:0] w, input logic [31:0] d,
                      input logic [31:0] r, input bit scramble);
      logic g;
      logic [127:0] edo;
      logic [127:0] ewn;
      int lat;
      model(p, w, d, r, g, edo, ewn);
      prev = p; weight = w; delta_in = d; rate = r; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check({tag, ".busy"}, 128'(busy), 128'd1);
      if (scramble) begin
         prev = {rv(), rv(), rv(), rv()}; weight = {rv(), rv(), rv(), rv()};
         delta_in = rv(); rate = rv();
      end
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
      check({tag, ".lat"}, 128'(lat), 128'd9);
      check({tag, ".busy_done"}, 128'(busy), 128'd0);
      check({tag, ".gate"}, 128'(gate), 128'(g));
      check({tag, ".dout"}, delta_out, edo);
      check({tag, ".wnew"}, weight_new, ewn);
      @(posedge clk); @(negedge clk);
      check({tag, ".done_pulse"}, 128'(done), 128'd0);
   endtask

   localparam logic [127:0] P_A   = {32'hFFFF0000, 32'h00008000, 32'h00020000, 32'h00010000};
   localparam logic [127:0] W_OFF = {32'h00020000, 32'h00010000, 32'h00004000, 32'h00008000};
   localparam logic [127:0] W_ON  = {32'h00008000, 32'h00010000, 32'h00004000, 32'h00008000};

   initial begin
      int dones;
      int first;
      int last;
      int lat;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.busy", 128'(busy), 128'd0);
      check("rst.done", 128'(done), 128'd0);
      check("rst.gate", 128'(gate), 128'd0);
      check("rst.dout", delta_out, 128'd0);
      check("rst.wnew", weight_new, 128'd0);
      check("rst.busy1", 128'(busy1), 128'd0);
      rst = 1'b0;

      op4("gate_off", P_A, W_OFF, 32'h8000, 32'h2000, 1'b0);
      check("gate_off.gate_c", 128'(gate), 128'd0);
      check("gate_off.dout_c", delta_out, 128'd0);
      check("gate_off.wnew_c", weight_new, W_OFF);

      op4("gate_on", P_A, W_ON, 32'h8000, 32'h2000, 1'b1);
      check("gate_on.gate_c", 128'(gate), 128'd1);
      check("gate_on.dout_c", delta_out, {32'h4000, 32'h8000, 32'h2000, 32'h4000});
      check("gate_on.wnew_c", weight_new, {32'h7000, 32'h10800, 32'h6000, 32'h9000});

      op4("zero", {32'h0, 32'h0, 32'h10000, 32'h10000}, {32'h0, 32'h0, 32'hFFFF0000, 32'h10000},
          32'h8000, 32'h2000, 1'b0);
      check("zero.gate_c", 128'(gate), 128'd1);
      check("zero.dout_c", delta_out, {32'h0, 32'h0, 32'hFFFF8000, 32'h8000});

      op4("ovf", {96'h0, 32'h007F0000}, {96'h0, 32'h7FFF0000}, 32'h10000, 32'h10000, 1'b0);
`ifdef BP_SATURATE_EN
      check("ovf.w0", 128'(weight_new[31:0]), 128'h7FFFFFFF);
`else
      check("ovf.w0", 128'(weight_new[31:0]), 128'h807E0000);
`endif

      for (int k = 0; k < 30; k++)
         op4($sformatf("rnd%0d", k), {rv(), rv(), rv(), rv()}, {rv(), rv(), rv(), rv()}, rv(), rv(), k[0]);

      prev = P_A; weight = W_ON; delta_in = 32'h8000; rate = 32'h2000; start = 1'b1;
      dones = 0; first = 0; last = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); @(negedge clk);
         if (done) begin
            dones++;
            if (dones == 1) first = k;
            else check("held.period", 128'(k - last), 128'd10);
            last = k;
         end
      end
      start = 1'b0;
      check("held.count", 128'(dones), 128'd4);
      check("held.first", 128'(first), 128'd9);

      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (6) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("abort.busy", 128'(busy), 128'd0);
      check("abort.done", 128'(done), 128'd0);
      check("abort.gate", 128'(gate), 128'd0);
      check("abort.dout", delta_out, 128'd0);
      check("abort.wnew", weight_new, 128'd0);
      rst = 1'b0;
      dones = 0;
      repeat (15) begin
         @(posedge clk); @(negedge clk);
         if (done) dones++;
      end
      check("abort.no_done", 128'(dones), 128'd0);

      rst = 1'b1; start = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rst_start.busy", 128'(busy), 128'd0);
      @(posedge clk); @(negedge clk);
      check("rst_start.busy2", 128'(busy), 128'd0);

      prev1 = 32'h20000; weight1 = 32'h30000; delta1 = 32'h10000; rate1 = 32'h8000; start1 = 1'b1;
      @(posedge clk); @(negedge clk);
      start1 = 1'b0;
      lat = 1;
      while (!done1 && lat < 20) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
      check("n1.lat", 128'(lat), 128'd3);
      check("n1.gate", 128'(gate1), 128'd1);
      check("n1.dout", 128'(dout1), 128'h30000);
      check("n1.wnew", 128'(wnew1), 128'h40000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
